// File: rtl/bkg_stream_arbiter.sv
// bkg_stream_arbiter
// Packet-granular round-robin arbiter that shares one background-subtraction
// datapath between two Avalon-ST sensor streams. Whole packets are forwarded
// and tagged with their source channel. Packets are forced to NUM_WORDS words:
// over-long packets are truncated with a forced EOP and their tail is flushed,
// and orphan words seen while idle are consumed and dropped.
//
// Handshake: a word moves on any Avalon-ST interface in a cycle where
// valid && ready are both 1 (readyLatency 0). Ready never depends on a word
// being held back; valid may drop between words.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                1 = new grants allowed, 0 = finish packet then idle
//   in0_* / in1_*         sink 0 / sink 1 (data, valid, ready, SOP, EOP, empty)
//   out_*                 source (data, valid, ready, SOP, EOP, empty=0)
//   out_channel           index of the sink that owns the current packet
//   pkt_cnt0 / pkt_cnt1   packets forwarded per sink, wrapping
//   len_err               sticky length / orphan error flag
//   dbg_state             current FSM state (0 idle, 1 xfer, 2 flush)
module bkg_stream_arbiter #(
  parameter int unsigned NUM_WORDS = 163
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] in0_data,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic        in0_startofpacket,
  input  logic        in0_endofpacket,
  input  logic [1:0]  in0_empty,
  input  logic [31:0] in1_data,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic        in1_startofpacket,
  input  logic        in1_endofpacket,
  input  logic [1:0]  in1_empty,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic        out_channel,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic        len_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  state_e      state_q;
  logic        sel_q;
  logic        last_grant_q;
  logic [7:0]  word_ctr_q;
  logic [15:0] pkt_cnt0_q;
  logic [15:0] pkt_cnt1_q;
  logic        len_err_q;

  // Selected-sink view.
  logic [31:0] sel_data;
  logic        sel_valid;
  logic        sel_sop;
  logic        sel_eop;
  logic        sel_ready;
  logic        sel_acc;
  logic        at_last;
  logic        xfer;

  // Idle-state arbitration.
  logic        orphan0;
  logic        orphan1;
  logic        req0;
  logic        req1;
  logic        winner;
  logic        orphan_acc;

  // The empty fields carry no information for full 32-bit words.
  logic        unused_empty;
  assign unused_empty = ^{in0_empty, in1_empty};

  assign sel_data  = sel_q ? in1_data          : in0_data;
  assign sel_valid = sel_q ? in1_valid         : in0_valid;
  assign sel_sop   = sel_q ? in1_startofpacket : in0_startofpacket;
  assign sel_eop   = sel_q ? in1_endofpacket   : in0_endofpacket;
  assign sel_ready = sel_q ? in1_ready         : in0_ready;
  assign sel_acc   = sel_valid && sel_ready;
  assign at_last   = (word_ctr_q == LAST_IDX);
  assign xfer      = (state_q == ST_XFER);

  assign orphan0    = in0_valid && !in0_startofpacket;
  assign orphan1    = in1_valid && !in1_startofpacket;
  assign req0       = in0_valid && in0_startofpacket && enable;
  assign req1       = in1_valid && in1_startofpacket && enable;
  // With a single request that requester wins; on a tie the sink that did
  // not win last time gets the grant.
  assign winner     = (req0 && req1) ? ~last_grant_q : req1;
  assign orphan_acc = (in0_valid && in0_ready) || (in1_valid && in1_ready);

  // Ready generation. In IDLE only orphans are taken (SOP words wait for the
  // grant); rst_n is folded in so readies are 0 while reset is held.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in0_ready = rst_n && orphan0;
        in1_ready = rst_n && orphan1;
      end
      ST_XFER: begin
        if (sel_q) in1_ready = out_ready;
        else       in0_ready = out_ready;
      end
      ST_FLUSH: begin
        if (sel_q) in1_ready = 1'b1;
        else       in0_ready = 1'b1;
      end
      default: begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
      end
    endcase
  end

  // Pure pass-through of the selected sink while transferring. EOP is forced
  // on the NUM_WORDS-th word so downstream always sees a fixed-size packet.
  assign out_valid         = xfer && sel_valid;
  assign out_data          = xfer ? sel_data : 32'd0;
  assign out_startofpacket = xfer && sel_valid && sel_sop;
  assign out_endofpacket   = xfer && sel_valid && (sel_eop || at_last);
  assign out_empty         = 2'd0;
  assign out_channel       = sel_q;
  assign pkt_cnt0          = pkt_cnt0_q;
  assign pkt_cnt1          = pkt_cnt1_q;
  assign len_err           = len_err_q;
  assign dbg_state         = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      word_ctr_q   <= 8'd0;
      pkt_cnt0_q   <= 16'd0;
      pkt_cnt1_q   <= 16'd0;
      len_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (orphan_acc) len_err_q <= 1'b1;
          // The SOP word itself stays on the sink and is passed through
          // in XFER on the following cycle.
          if (req0 || req1) begin
            sel_q        <= winner;
            last_grant_q <= winner;
            word_ctr_q   <= 8'd0;
            state_q      <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (sel_acc) begin
            word_ctr_q <= word_ctr_q + 8'd1;
            if (sel_eop || at_last) begin
              // Error when EOP arrives early, or when the packet has not
              // ended by its last allowed word.
              if (sel_eop != at_last) len_err_q <= 1'b1;
              if (sel_q) pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
              else       pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
              state_q <= sel_eop ? ST_IDLE : ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (sel_acc && sel_eop) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bkg_stream_arbiter.md
Name: bkg_stream_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one background-subtraction datapath between two sensor-board Avalon-ST streams.
- Each input packet is NUM_WORDS words: 3 header words followed by data words.
- Sits between the two readout front-ends and the background-subtraction stage. Forwards whole packets only and tags each one with its source channel.
- Enforces packet length: truncates over-long packets and drops orphan words, so downstream frame/word counters never desynchronise.

Parameters:
- NUM_WORDS, 163, expected words per packet including SOP and EOP words (range 4..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = new grants allowed; 0 = finish current packet, then stay idle
- in0_data  in  32  sink 0 data
- in0_valid  in  1  sink 0 valid
- in0_ready  out  1  sink 0 ready (0 readLatency)
- in0_startofpacket  in  1  sink 0 SOP
- in0_endofpacket  in  1  sink 0 EOP
- in0_empty  in  2  sink 0 empty (ignored)
- in1_data / in1_valid / in1_ready / in1_startofpacket / in1_endofpacket / in1_empty  same as sink 0, for sink 1
- out_data  out  32  source data
- out_valid  out  1  source valid
- out_ready  in  1  source ready
- out_startofpacket  out  1  source SOP
- out_endofpacket  out  1  source EOP
- out_empty  out  2  constant 0
- out_channel  out  1  source index of the current packet; valid with out_valid
- pkt_cnt0  out  16  packets forwarded from sink 0; wraps at 0xFFFF
- pkt_cnt1  out  16  packets forwarded from sink 1; wraps at 0xFFFF
- len_err  out  1  sticky: a packet had the wrong length or an orphan word was dropped; cleared only by reset

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, sel=0, last_grant=1 (sink 0 wins the first tie), word_ctr=0.
  - pkt_cnt0=pkt_cnt1=0, len_err=0.
  - All ready, valid, SOP, EOP outputs 0; out_data=0; out_channel=0.
- A word is accepted on a sink when valid && ready in the same cycle.
- IDLE:
  - in0_ready and in1_ready are 1 only for words that have valid && !startofpacket. Those are orphans: dropped, and len_err set.
  - A request is valid && startofpacket && enable.
  - One request: grant it. Two requests: grant !last_grant.
  - On grant: sel<=winner, last_grant<=winner, word_ctr<=0, go to XFER. The SOP word is not consumed in IDLE.
  - Grant latency is 1 cycle: SOP is offered on the source the cycle after it appears.
- XFER, pure combinational pass-through with no storage:
  - out_data, out_valid, out_startofpacket come from the selected sink.
  - in_sel_ready=out_ready; the unselected sink has ready=0.
  - out_channel=sel.
  - On each accepted word, word_ctr increments.
  - Accepted word with EOP: if word_ctr != NUM_WORDS-1, set len_err. Increment pkt_cnt[sel], go to IDLE.
  - Accepted word at word_ctr == NUM_WORDS-1 without EOP: force out_endofpacket=1 on that word, set len_err, increment pkt_cnt[sel], go to FLUSH.
  - A mid-packet SOP on the selected sink is forwarded unchanged and does not reset word_ctr.
- FLUSH:
  - Selected sink ready=1; words are discarded and out_valid=0.
  - On an accepted EOP go to IDLE.
- Back-to-back operation: after a packet ends, the next grant is evaluated in IDLE, giving a 1-cycle bubble between packets.
- enable deassertion mid-packet has no effect until the packet completes.
- Backpressure: out_ready=0 holds everything. word_ctr and the state do not change.

Test Plan:
- Only sink 0 sends two 163-word packets with out_ready=1:
  - output shows 2×163 words, out_channel=0, SOP on words 0 and 163, EOP on words 162 and 325.
  - pkt_cnt0=2, len_err=0.
- Both sinks hold SOP asserted in the same cycle after reset:
  - output order is packet from sink 0, then sink 1, then sink 0.
  - exactly one idle cycle between packets; pkt_cnt0=2, pkt_cnt1=1.
- out_ready toggles with a 50% random pattern during sink 1 packet:
  - output data matches input word-for-word with no duplicates or losses.
  - in1_ready equals out_ready in every XFER cycle.
- Sink 0 sends a 170-word packet:
  - output has 163 words, forced EOP on word 162, remaining 7 words discarded.
  - len_err=1; the next sink 0 packet is forwarded normally.
- Sink 1 sends a 100-word packet with EOP: 100 words forwarded, len_err=1, pkt_cnt1 increments.
- Orphan word (valid, no SOP) in IDLE: consumed and not forwarded, len_err=1.
- enable=0 asserted mid-packet: packet completes, no further grants.
- rst_n pulsed mid-XFER: all outputs return to 0 immediately (asynchronously) and the counters clear.
